// File: rtl/md_hilo_sequencer.sv
// Multiply/divide sequencer with HI/LO registers for the 5-stage pipeline.
// Holds a precomputed result for a fixed latency, then commits it to HI/LO.
module md_hilo_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  E_Op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_UsesHiLo,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [31:0]   r_hi, w_hi_nx;
  logic [31:0]   r_lo, w_lo_nx;
  logic [31:0]   r_pend_hi, w_pend_hi_nx;
  logic [31:0]   r_pend_lo, w_pend_lo_nx;
  logic          r_pend_wr, w_pend_wr_nx;

  logic          w_is_md;
  logic          w_start;
  logic [63:0]   w_smul;
  logic [63:0]   w_umul;
  logic          w_divz;
  logic          w_ovf;
  logic [31:0]   w_db;
  logic [31:0]   w_sq;
  logic [31:0]   w_sr;
  logic [31:0]   w_uq;
  logic [31:0]   w_ur;

  assign w_is_md = (E_Op == OP_MULT)  | (E_Op == OP_MULTU) |
                   (E_Op == OP_DIV)   | (E_Op == OP_DIVU);
  assign w_start = w_is_md & (r_state == S_IDLE);

  assign w_smul = $signed({{32{E_A[31]}}, E_A}) *
                  $signed({{32{E_B[31]}}, E_B});
  assign w_umul = {32'b0, E_A} * {32'b0, E_B};

  // Divisor forced nonzero so the dividers never see x; the
  // zero case is tracked separately and suppresses the commit.
  assign w_divz = (E_B == 32'b0);
  assign w_ovf  = (E_A == 32'h8000_0000) & (E_B == 32'hFFFF_FFFF);
  assign w_db   = w_divz ? 32'd1 : E_B;
  assign w_sq   = w_ovf ? 32'h8000_0000 :
                  $unsigned($signed(E_A) / $signed(w_db));
  assign w_sr   = w_ovf ? 32'h0 :
                  $unsigned($signed(E_A) % $signed(w_db));
  assign w_uq   = E_A / w_db;
  assign w_ur   = E_A % w_db;

  always_comb begin
    w_pend_hi_nx = r_pend_hi;
    w_pend_lo_nx = r_pend_lo;
    w_pend_wr_nx = r_pend_wr;
    if (w_start) begin
      unique case (1'b1)
        (E_Op == OP_MULT): begin
          w_pend_hi_nx = w_smul[63:32];
          w_pend_lo_nx = w_smul[31:0];
          w_pend_wr_nx = 1'b1;
        end
        (E_Op == OP_MULTU): begin
          w_pend_hi_nx = w_umul[63:32];
          w_pend_lo_nx = w_umul[31:0];
          w_pend_wr_nx = 1'b1;
        end
        (E_Op == OP_DIV): begin
          w_pend_hi_nx = w_sr;
          w_pend_lo_nx = w_sq;
          w_pend_wr_nx = ~w_divz;
        end
        default: begin
          w_pend_hi_nx = w_ur;
          w_pend_lo_nx = w_uq;
          w_pend_wr_nx = ~w_divz;
        end
      endcase
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nx = S_BUSY;
          w_cnt_nx   = ((E_Op == OP_MULT) | (E_Op == OP_MULTU)) ?
                       MULT_LD : DIV_LD;
        end else if (E_Op == OP_MTHI) begin
          w_hi_nx = E_A;
        end else if (E_Op == OP_MTLO) begin
          w_lo_nx = E_A;
        end
      end
      S_BUSY: begin
        w_cnt_nx = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_state_nx = S_IDLE;
          if (r_pend_wr) begin
            w_hi_nx = r_pend_hi;
            w_lo_nx = r_pend_lo;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_hi      <= w_hi_nx;
      r_lo      <= w_lo_nx;
      r_pend_hi <= w_pend_hi_nx;
      r_pend_lo <= w_pend_lo_nx;
      r_pend_wr <= w_pend_wr_nx;
    end
  end

  assign Busy  = (r_state == S_BUSY);
  assign Stall = D_UsesHiLo & (w_start | Busy);
  assign HI    = r_hi;
  assign LO    = r_lo;

endmodule

// File: tb/tb_md_hilo_sequencer.sv
// Directed vector bench for md_hilo_sequencer.
// Vectors run in order; each expected HI/LO assumes the prior state.
module tb_md_hilo_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [2:0]  E_Op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_UsesHiLo;
  logic        Busy;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  md_hilo_sequencer #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .E_Op      (E_Op),
    .E_A       (E_A),
    .E_B       (E_B),
    .D_UsesHiLo(D_UsesHiLo),
    .Busy      (Busy),
    .Stall     (Stall),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        duse;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a sample point (just after a negedge); returns at one.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    logic st_exp;
    E_Op = v.op;
    E_A = v.a;
    E_B = v.b;
    D_UsesHiLo = v.duse;
    #1;
    st_exp = v.duse & (v.op >= 3'd1) & (v.op <= 3'd4);
    chk($sformatf("v%0d stall_start", idx), {31'b0, Stall},
        {31'b0, st_exp});
    @(posedge Clk);
    @(negedge Clk);
    E_Op = 3'b000;
    #1;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      chk($sformatf("v%0d stall_busy%0d", idx, n), {31'b0, Stall},
          {31'b0, v.duse});
      @(negedge Clk);
      #1;
    end
    chk($sformatf("v%0d busy_cycles", idx), n, v.cyc);
    chk($sformatf("v%0d hi", idx), HI, v.hi);
    chk($sformatf("v%0d lo", idx), LO, v.lo);
    chk($sformatf("v%0d stall_after", idx), {31'b0, Stall}, 32'd0);
  endtask

  vec_t vt[14];

  initial begin
    int n;
    vt[0]  = '{3'b001, 32'hFFFFFFFE, 32'd3, 1'b0,
               32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vt[1]  = '{3'b010, 32'hFFFFFFFF, 32'd2, 1'b0,
               32'h00000001, 32'hFFFFFFFE, 5};
    vt[2]  = '{3'b011, 32'hFFFFFFF9, 32'd2, 1'b1,
               32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[3]  = '{3'b100, 32'd7, 32'd0, 1'b0,
               32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[4]  = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 1'b0,
               32'h00000000, 32'h80000000, 10};
    vt[5]  = '{3'b100, 32'd100, 32'd7, 1'b1,
               32'h00000002, 32'h0000000E, 10};
    vt[6]  = '{3'b101, 32'h12345678, 32'd0, 1'b1,
               32'h12345678, 32'h0000000E, 0};
    vt[7]  = '{3'b110, 32'h9ABCDEF0, 32'd0, 1'b1,
               32'h12345678, 32'h9ABCDEF0, 0};
    vt[8]  = '{3'b011, 32'd7, 32'hFFFFFFFE, 1'b0,
               32'h00000001, 32'hFFFFFFFD, 10};
    vt[9]  = '{3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0,
               32'h3FFFFFFF, 32'h00000001, 5};
    vt[10] = '{3'b010, 32'h80000000, 32'h80000000, 1'b0,
               32'h40000000, 32'h00000000, 5};
    vt[11] = '{3'b001, 32'hFFFFFFFF, 32'd1, 1'b0,
               32'hFFFFFFFF, 32'hFFFFFFFF, 5};
    vt[12] = '{3'b111, 32'd5, 32'd9, 1'b1,
               32'hFFFFFFFF, 32'hFFFFFFFF, 0};
    vt[13] = '{3'b011, 32'hFFFFFFF8, 32'd3, 1'b0,
               32'hFFFFFFFE, 32'hFFFFFFFE, 10};

    Reset = 1'b1;
    E_Op = 3'b000;
    E_A = '0;
    E_B = '0;
    D_UsesHiLo = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_stall", {31'b0, Stall}, 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vt[i], i);

    // Start and mthi presented while busy must be ignored.
    E_Op = 3'b001;
    E_A = 32'd3;
    E_B = 32'd4;
    D_UsesHiLo = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    E_Op = 3'b011;
    E_A = 32'd100;
    E_B = 32'd7;
    #1;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      @(negedge Clk);
      if (n == 1) begin
        E_Op = 3'b101;
        E_A = 32'hDEADBEEF;
      end else begin
        E_Op = 3'b000;
      end
      #1;
    end
    chk("ign_cycles", n, 5);
    chk("ign_hi", HI, 32'd0);
    chk("ign_lo", LO, 32'd12);

    // Reset during the 4th busy cycle of a divide.
    E_Op = 3'b100;
    E_A = 32'd100;
    E_B = 32'd7;
    D_UsesHiLo = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    E_Op = 3'b000;
    repeat (3) @(negedge Clk);
    #1;
    chk("mid_busy", {31'b0, Busy}, 32'd1);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    #1;
    chk("mrst_hi", HI, 32'd0);
    chk("mrst_lo", LO, 32'd0);
    chk("mrst_busy", {31'b0, Busy}, 32'd0);
    chk("mrst_stall", {31'b0, Stall}, 32'd0);
    Reset = 1'b0;
    repeat (12) @(negedge Clk);
    #1;
    chk("late_hi", HI, 32'd0);
    chk("late_lo", LO, 32'd0);
    chk("late_busy", {31'b0, Busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
